// File: rtl/fx2_in_ep_fifo.sv
// FX2 slave-FIFO IN endpoint model: buffers FPGA-side writes, commits USB packets, host drains them.
// Optional macro FX2_ZLP_EN: PKTEND with nothing pending commits a zero-length packet.
module fx2_in_ep_fifo #(
    parameter logic [1:0] FIFOADR     = 2'b00,
    parameter int         WIDTH       = 8,
    parameter int         DEPTH       = 1024,
    parameter int         PKT_WORDS   = 256,
    parameter int         FULL_LEVEL  = 0,
    parameter int         PKT_Q_DEPTH = 4
) (
    input  logic                         ifclk,
    input  logic                         reset,
    input  logic [1:0]                   fifoadr,
    input  logic [WIDTH-1:0]             data,
    input  logic                         wr,
    input  logic                         pktend,
    output logic                         full,
    input  logic                         host_rd,
    output logic [WIDTH-1:0]             host_data,
    output logic                         host_valid,
    output logic                         host_last,
    output logic                         host_zlp,
    output logic [$clog2(PKT_Q_DEPTH):0] host_pkts
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = CW + 1;
    localparam int LW = $clog2(PKT_WORDS) + 1;
    localparam int QA = (PKT_Q_DEPTH > 1) ? $clog2(PKT_Q_DEPTH) : 1;
    localparam int QW = $clog2(PKT_Q_DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    desc_mem [PKT_Q_DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [LW-1:0] pending_q, pending_d, drained_q, drained_d;
    logic [CW-1:0] committed_q, committed_d;
    logic [QW-1:0] host_pkts_q, host_pkts_d;
    logic [QA-1:0] qwr_q, qwr_d, qrd_q, qrd_d;

    logic          sel, q_full, wr_acc, pe, push, zlp_allow, pop_word, retire;
    logic [FW-1:0] free_words;
    logic [LW-1:0] pend_inc, push_len, head_len, remaining;

    function automatic logic [QA-1:0] q_next(input logic [QA-1:0] p);
        return (p == QA'(PKT_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FX2_ZLP_EN
    assign zlp_allow = 1'b1;
`else
    assign zlp_allow = 1'b0;
`endif

    always_comb begin
        sel        = (fifoadr == FIFOADR);
        free_words = FW'(DEPTH) - FW'(committed_q) - FW'(pending_q);
        q_full     = (host_pkts_q == QW'(PKT_Q_DEPTH));
        full       = (free_words <= FW'(FULL_LEVEL)) | q_full;
        wr_acc     = sel & wr & ~full;
        pend_inc   = pending_q + LW'(wr_acc);
        pe         = sel & pktend & ~q_full;

        // Auto-commit takes priority; a coincident pktend then has nothing left to close.
        push      = 1'b0;
        push_len  = '0;
        pending_d = pend_inc;
        if (wr_acc && (pend_inc == LW'(PKT_WORDS))) begin
            push      = 1'b1;
            push_len  = pend_inc;
            pending_d = '0;
        end else if (pe && (pend_inc != '0)) begin
            push      = 1'b1;
            push_len  = pend_inc;
            pending_d = '0;
        end else if (pe && zlp_allow) begin
            push = 1'b1;
        end

        head_len   = desc_mem[qrd_q];
        remaining  = head_len - drained_q;
        host_valid = (host_pkts_q != '0);
        host_zlp   = host_valid & zlp_allow & (head_len == '0);
        host_last  = host_valid & ((remaining == LW'(1)) | host_zlp);
        host_data  = mem[tail_q];
        host_pkts  = host_pkts_q;

        // A zero-length packet retires without moving the read pointer.
        pop_word = host_rd & host_valid & ~host_zlp;
        retire   = host_rd & host_last;

        head_d      = head_q + AW'(wr_acc);
        tail_d      = tail_q + AW'(pop_word);
        drained_d   = retire ? '0 : drained_q + LW'(pop_word);
        committed_d = committed_q + (push ? CW'(push_len) : '0) - CW'(pop_word);
        host_pkts_d = host_pkts_q + QW'(push) - QW'(retire);
        qwr_d       = push ? q_next(qwr_q) : qwr_q;
        qrd_d       = retire ? q_next(qrd_q) : qrd_q;
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            pending_q   <= '0;
            drained_q   <= '0;
            committed_q <= '0;
            host_pkts_q <= '0;
            qwr_q       <= '0;
            qrd_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            pending_q   <= pending_d;
            drained_q   <= drained_d;
            committed_q <= committed_d;
            host_pkts_q <= host_pkts_d;
            qwr_q       <= qwr_d;
            qrd_q       <= qrd_d;
        end
    end

    // Storage is not reset; writes in a reset cycle are dropped.
    always_ff @(posedge ifclk) begin
        if (wr_acc && !reset) mem[head_q] <= data;
        if (push && !reset) desc_mem[qwr_q] <= push_len;
    end
endmodule
